// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: a direct-mapped BTB with a 2-bit direction
// counter per entry. Lookup is combinational from the table. Resolved
// outcomes from execute train the table. A mispredict produces a registered
// one-cycle redirect pulse back to fetch.
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_fetch_pc,
    output logic            o_pred_hit,
    output logic            o_pred_taken,
    output logic [XLEN-1:0] o_pred_target,
    input  logic            i_upd_valid,
    input  logic [XLEN-1:0] i_upd_pc,
    input  logic            i_upd_is_jump,
    input  logic            i_upd_taken,
    input  logic [XLEN-1:0] i_upd_target,
    input  logic            i_upd_pred_taken,
    input  logic [XLEN-1:0] i_upd_pred_target,
    output logic            o_mispredict,
    output logic [XLEN-1:0] o_redirect_pc
);

    localparam int IDX_W = $clog2(ENTRIES);

    // Flattened view of the per-entry state, assembled from the generate loop
    logic [ENTRIES-1:0] valid_vec;
    logic [ENTRIES-1:0] jump_vec;
    logic [1:0]         ctr_arr    [ENTRIES];
    logic [TAG_W-1:0]   tag_arr    [ENTRIES];
    logic [XLEN-1:0]    target_arr [ENTRIES];

    // Fetch-side index/tag split (PC bits [1:0] never participate)
    logic [IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    assign fetch_idx = i_fetch_pc[IDX_W+1:2];
    assign fetch_tag = i_fetch_pc[IDX_W+TAG_W+1:IDX_W+2];

    // Update-side index/tag split and hit test against the current table
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    assign upd_idx = i_upd_pc[IDX_W+1:2];
    assign upd_tag = i_upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign upd_hit = valid_vec[upd_idx] && (tag_arr[upd_idx] == upd_tag);

    // Lookup reads the registered table only, so a same-cycle update to the
    // same index is not visible until the following cycle.
    assign o_pred_hit    = valid_vec[fetch_idx] && (tag_arr[fetch_idx] == fetch_tag);
    assign o_pred_taken  = o_pred_hit && (jump_vec[fetch_idx] || ctr_arr[fetch_idx][1]);
    assign o_pred_target = o_pred_taken ? target_arr[fetch_idx] : (i_fetch_pc + XLEN'(4));

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic             entry_valid_reg;
            logic             entry_jump_reg;
            logic [1:0]       entry_ctr_reg;
            logic [TAG_W-1:0] entry_tag_reg;
            logic [XLEN-1:0]  entry_target_reg;
            logic             entry_sel;
            logic             entry_alloc;
            logic             entry_write;

            // A flush suppresses every table write, not just the valid bits
            assign entry_sel   = i_upd_valid && !i_flush && (upd_idx == IDX_W'(gi));
            assign entry_alloc = entry_sel && !upd_hit && i_upd_taken;
            assign entry_write = entry_sel && i_upd_taken;

            // Valid, direction counter and jump flag: reset to a weak not-taken
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    entry_valid_reg <= 1'b0;
                    entry_ctr_reg   <= 2'b01;
                    entry_jump_reg  <= 1'b0;
                end else begin
                    if (i_flush) begin
                        entry_valid_reg <= 1'b0;
                    end else if (entry_alloc) begin
                        entry_valid_reg <= 1'b1;
                    end

                    if (entry_sel && upd_hit) begin
                        if (i_upd_is_jump) begin
                            entry_ctr_reg <= 2'b11;
                        end else if (i_upd_taken && entry_ctr_reg != 2'b11) begin
                            entry_ctr_reg <= entry_ctr_reg + 2'b01;
                        end else if (!i_upd_taken && entry_ctr_reg != 2'b00) begin
                            entry_ctr_reg <= entry_ctr_reg - 2'b01;
                        end
                    end else if (entry_alloc) begin
                        entry_ctr_reg <= i_upd_is_jump ? 2'b11 : 2'b10;
                    end

                    if (entry_write) begin
                        entry_jump_reg <= i_upd_is_jump;
                    end
                end
            end

            // Tag and target carry no reset; they are only observed behind valid
            always_ff @(posedge i_clk) begin
                if (entry_alloc) begin
                    entry_tag_reg <= upd_tag;
                end
                if (entry_write) begin
                    entry_target_reg <= i_upd_target;
                end
            end

            assign valid_vec[gi]  = entry_valid_reg;
            assign jump_vec[gi]   = entry_jump_reg;
            assign ctr_arr[gi]    = entry_ctr_reg;
            assign tag_arr[gi]    = entry_tag_reg;
            assign target_arr[gi] = entry_target_reg;
        end
    endgenerate

    // Wrong direction, or taken to a different target than predicted
    logic            mispredict_next;
    logic            mispredict_reg;
    logic [XLEN-1:0] redirect_reg;
    assign mispredict_next = i_upd_valid &&
                             ((i_upd_taken != i_upd_pred_taken) ||
                              (i_upd_taken && (i_upd_target != i_upd_pred_target)));

    // Registered redirect; the PC only moves when a mispredict is signalled
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mispredict_reg <= 1'b0;
            redirect_reg   <= '0;
        end else begin
            mispredict_reg <= mispredict_next;
            if (mispredict_next) begin
                redirect_reg <= i_upd_taken ? i_upd_target : (i_upd_pc + XLEN'(4));
            end
        end
    end

    assign o_mispredict  = mispredict_reg;
    assign o_redirect_pc = redirect_reg;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: stimulus pushes expected lookup and
// mispredict responses into a scoreboard; a negedge monitor pops and compares.
module tb_branch_predictor;

    logic        i_clk;
    logic        i_rst;
    logic        i_flush;
    logic [31:0] i_fetch_pc;
    logic        o_pred_hit;
    logic        o_pred_taken;
    logic [31:0] o_pred_target;
    logic        i_upd_valid;
    logic [31:0] i_upd_pc;
    logic        i_upd_is_jump;
    logic        i_upd_taken;
    logic [31:0] i_upd_target;
    logic        i_upd_pred_taken;
    logic [31:0] i_upd_pred_target;
    logic        o_mispredict;
    logic [31:0] o_redirect_pc;

    branch_predictor #(.XLEN(32), .ENTRIES(64), .TAG_W(8)) dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_flush           (i_flush),
        .i_fetch_pc        (i_fetch_pc),
        .o_pred_hit        (o_pred_hit),
        .o_pred_taken      (o_pred_taken),
        .o_pred_target     (o_pred_target),
        .i_upd_valid       (i_upd_valid),
        .i_upd_pc          (i_upd_pc),
        .i_upd_is_jump     (i_upd_is_jump),
        .i_upd_taken       (i_upd_taken),
        .i_upd_target      (i_upd_target),
        .i_upd_pred_taken  (i_upd_pred_taken),
        .i_upd_pred_target (i_upd_pred_target),
        .o_mispredict      (o_mispredict),
        .o_redirect_pc     (o_redirect_pc)
    );

    typedef struct {
        int          cyc;
        bit          is_mp;
        logic        hit;
        logic        taken;
        logic [31:0] tgt;
        logic        mp;
        logic [31:0] rd;
        string       nm;
    } exp_t;

    exp_t sb_q[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compare every expectation due in the current cycle
    exp_t e;
    always @(negedge i_clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            if (e.cyc != cyc) cmp({e.nm, "_late"}, 32'(cyc), 32'(e.cyc));
            if (e.is_mp) begin
                cmp({e.nm, "_mp"}, {31'b0, o_mispredict}, {31'b0, e.mp});
                if (e.mp) cmp({e.nm, "_redirect"}, o_redirect_pc, e.rd);
            end else begin
                cmp({e.nm, "_hit"}, {31'b0, o_pred_hit}, {31'b0, e.hit});
                cmp({e.nm, "_taken"}, {31'b0, o_pred_taken}, {31'b0, e.taken});
                cmp({e.nm, "_target"}, o_pred_target, e.tgt);
            end
            $display("check %s @%0d", e.nm, cyc);
        end
    end

    // One transaction per cycle: fetch lookup (optionally checked this cycle)
    // plus an update whose mispredict result is checked next cycle.
    task automatic apply(input string nm, input logic [31:0] fpc, input bit chk,
                         input logic e_hit, input logic e_tk, input logic [31:0] e_tgt,
                         input bit uv, input logic [31:0] upc, input bit jmp, input bit tk,
                         input logic [31:0] ut, input bit ptk, input logic [31:0] pt,
                         input bit fl, input bit e_mp, input logic [31:0] e_rd);
        exp_t x;
        @(posedge i_clk);
        #1;
        i_fetch_pc        = fpc;
        i_upd_valid       = uv;
        i_upd_pc          = upc;
        i_upd_is_jump     = jmp;
        i_upd_taken       = tk;
        i_upd_target      = ut;
        i_upd_pred_taken  = ptk;
        i_upd_pred_target = pt;
        i_flush           = fl;
        if (chk) begin
            x.cyc = cyc; x.is_mp = 1'b0; x.hit = e_hit; x.taken = e_tk; x.tgt = e_tgt;
            x.mp = 1'b0; x.rd = 32'h0; x.nm = nm;
            sb_q.push_back(x);
        end
        x.cyc = cyc + 1; x.is_mp = 1'b1; x.hit = 1'b0; x.taken = 1'b0; x.tgt = 32'h0;
        x.mp = e_mp; x.rd = e_rd; x.nm = nm;
        sb_q.push_back(x);
    endtask

    initial begin
        i_rst = 1'b1; i_flush = 1'b0; i_fetch_pc = 32'h0; i_upd_valid = 1'b0;
        i_upd_pc = 32'h0; i_upd_is_jump = 1'b0; i_upd_taken = 1'b0; i_upd_target = 32'h0;
        i_upd_pred_taken = 1'b0; i_upd_pred_target = 32'h0;
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;

        //     name           fetch pc     chk hit tk  exp target    uv upd pc      j  tk upd tgt     ptk pred tgt   fl mp redirect
        apply("reset_lookup", 32'h100,     1,  0,  0,  32'h104,      0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      0, 0, 32'h0);
        apply("alloc_miss",   32'h100,     1,  0,  0,  32'h104,      1, 32'h100,    0, 1, 32'h200,    0, 32'h104,    0, 1, 32'h200);
        apply("alloc_hit",    32'h100,     1,  1,  1,  32'h200,      1, 32'h100,    0, 0, 32'h0,      1, 32'h200,    0, 1, 32'h104);
        apply("ctr01",        32'h100,     1,  1,  0,  32'h104,      1, 32'h100,    0, 0, 32'h0,      0, 32'h104,    0, 0, 32'h0);
        apply("ctr00_a",      32'h100,     1,  1,  0,  32'h104,      1, 32'h100,    0, 0, 32'h0,      0, 32'h104,    0, 0, 32'h0);
        apply("ctr00_b",      32'h100,     1,  1,  0,  32'h104,      1, 32'h100,    0, 0, 32'h0,      0, 32'h104,    0, 0, 32'h0);
        apply("inc_a",        32'h100,     1,  1,  0,  32'h104,      1, 32'h100,    0, 1, 32'h200,    0, 32'h104,    0, 1, 32'h200);
        apply("inc_b",        32'h100,     1,  1,  0,  32'h104,      1, 32'h100,    0, 1, 32'h200,    0, 32'h104,    0, 1, 32'h200);
        apply("inc_c",        32'h100,     1,  1,  1,  32'h200,      1, 32'h100,    0, 1, 32'h200,    1, 32'h200,    0, 0, 32'h0);
        apply("inc_d",        32'h100,     1,  1,  1,  32'h200,      1, 32'h100,    0, 1, 32'h200,    1, 32'h200,    0, 0, 32'h0);
        apply("sat_dec",      32'h100,     1,  1,  1,  32'h200,      1, 32'h100,    0, 0, 32'h0,      1, 32'h200,    0, 1, 32'h104);
        apply("sat_chk",      32'h100,     1,  1,  1,  32'h200,      0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      0, 0, 32'h0);
        apply("alias_tag",    32'h1100,    1,  0,  0,  32'h1104,     0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      0, 0, 32'h0);
        apply("alias_hi",     32'h10100,   1,  1,  1,  32'h200,      1, 32'h100,    0, 1, 32'h240,    1, 32'h200,    0, 1, 32'h240);
        apply("tgt_rewrite",  32'h100,     1,  1,  1,  32'h240,      1, 32'h300,    1, 1, 32'h80,     1, 32'h80,     0, 0, 32'h0);
        apply("jump_hit",     32'h300,     1,  1,  1,  32'h80,       0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      0, 0, 32'h0);
        apply("flush_upd",    32'h100,     1,  0,  0,  32'h104,      1, 32'h400,    0, 1, 32'h900,    0, 32'h404,    1, 1, 32'h900);
        apply("flush_300",    32'h300,     1,  0,  0,  32'h304,      0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      0, 0, 32'h0);
        apply("flush_400",    32'h400,     1,  0,  0,  32'h404,      0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      0, 0, 32'h0);
        apply("realloc",      32'h100,     1,  0,  0,  32'h104,      1, 32'h100,    0, 1, 32'h200,    0, 32'h104,    0, 1, 32'h200);
        apply("pre_rst",      32'h100,     1,  1,  1,  32'h200,      1, 32'h540,    0, 1, 32'h600,    0, 32'h544,    0, 0, 32'h0);

        // Asynchronous reset mid-cycle with an update still pending
        #5 i_rst = 1'b1;
        #1;
        cmp("async_rst_mp", {31'b0, o_mispredict}, 32'h0);
        cmp("async_rst_redirect", o_redirect_pc, 32'h0);
        cmp("async_rst_hit", {31'b0, o_pred_hit}, 32'h0);
        cmp("async_rst_target", o_pred_target, 32'h104);
        $display("check async_rst @%0d", cyc);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0; i_upd_valid = 1'b0; i_flush = 1'b0;

        apply("rst_discard",  32'h540,     1,  0,  0,  32'h544,      0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      0, 0, 32'h0);
        apply("rst_cleared",  32'h100,     1,  0,  0,  32'h104,      0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      0, 0, 32'h0);
        apply("wrap",         32'hFFFFFFFC,1,  0,  0,  32'h0,        1, 32'hFFFFFFFC,0, 0, 32'h0,      1, 32'h100,    0, 1, 32'h0);
        apply("idle_end",     32'h0,       1,  0,  0,  32'h4,        0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      0, 0, 32'h0);

        repeat (3) @(posedge i_clk);
        #1;
        cmp("sb_drain", 32'(sb_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
